sat_add_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one saturating adder between NREQ requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants at most one requester per cycle and computes the saturated sum a+b clamped to OUT_W bits. It returns the registered result on a single response channel, tagged with the requester index. The block sits between the client ports and the downstream consumer, replacing one saturating adder per client.

---
 rtl/sat_add_arbiter_if.sv | 35 +++
 rtl/sat_add_arbiter.sv | 111 +++++++++++
 tb/tb_sat_add_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sat_add_arbiter_if.sv
// ============================================================================
// Module : sat_add_arbiter_if
// Brief  : Requester and response bus bundle for sat_add_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sat_add_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 4,
    parameter int ID_W  = $clog2(NREQ)
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*IN_W-1:0] req_a;
    logic [NREQ*IN_W-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [OUT_W-1:0]     rsp_sum;
    logic                 rsp_sat;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_sat
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_sat
    );
endinterface

`default_nettype wire

// File: rtl/sat_add_arbiter.sv
// ============================================================================
// Module : sat_add_arbiter
// Brief  : Round-robin arbiter sharing one saturating adder among NREQ clients.
//          Optional saturation counter enabled by macro SAT_ARB_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_add_arbiter #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 4,
    parameter int ID_W  = $clog2(NREQ)
) (
    input  wire logic        clk,
    input  wire logic        rst_b,
`ifdef SAT_ARB_STATS_EN
    output logic [15:0]      sat_count,
`endif
    sat_add_arbiter_if.slave bus
);

    localparam logic [IN_W:0] c_LIMIT = (IN_W+1)'((1 << OUT_W) - 1);

    logic [ID_W-1:0]  r_ptr;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [OUT_W-1:0] r_rsp_sum;
    logic             r_rsp_sat;

    logic             w_can_accept;
    logic             w_found;
    logic [ID_W-1:0]  w_gnt;
    int unsigned      w_idx;
    logic [NREQ-1:0]  w_ready;
    logic             w_xfer;
    logic [IN_W-1:0]  w_a;
    logic [IN_W-1:0]  w_b;
    logic [IN_W:0]    w_full;
    logic             w_sat;
    logic [OUT_W-1:0] w_sum;

    assign w_can_accept = !r_rsp_valid || bus.rsp_ready;

    // Search starts one past the last grant and wraps, giving round-robin order.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = ID_W'(w_idx);
            end
        end
    end

    // rst_b gating keeps req_ready low while the registers are held in reset.
    assign w_ready       = (w_found && w_can_accept && rst_b) ? (NREQ'(1) << w_gnt) : '0;
    assign bus.req_ready = w_ready;
    assign w_xfer        = |(bus.req_valid & w_ready);

    assign w_a    = bus.req_a[w_gnt*IN_W +: IN_W];
    assign w_b    = bus.req_b[w_gnt*IN_W +: IN_W];
    assign w_full = {1'b0, w_a} + {1'b0, w_b};
    assign w_sat  = (w_full > c_LIMIT);
    assign w_sum  = w_sat ? {OUT_W{1'b1}} : w_full[OUT_W-1:0];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ptr       <= ID_W'(NREQ - 1);
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_rsp_sat   <= 1'b0;
        end else if (w_can_accept) begin
            if (w_xfer) begin
                r_ptr       <= w_gnt;
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= w_gnt;
                r_rsp_sum   <= w_sum;
                r_rsp_sat   <= w_sat;
            end else begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_sat   = r_rsp_sat;

`ifdef SAT_ARB_STATS_EN
    logic [15:0] r_sat_count;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_sat_count <= '0;
        end else if (w_xfer && w_sat && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign sat_count = r_sat_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sat_add_arbiter.sv
// ============================================================================
// Module : tb_sat_add_arbiter
// Brief  : Directed self-checking bench for sat_add_arbiter (NREQ=4, IN_W=8, OUT_W=4).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sat_add_arbiter;

    localparam int NREQ  = 4;
    localparam int IN_W  = 8;
    localparam int OUT_W = 4;
    localparam int ID_W  = 2;

    logic clk;
    logic rst_b;
    int   n_pass;
    int   n_total;
`ifdef SAT_ARB_STATS_EN
    logic [15:0] sat_count;
`endif

    sat_add_arbiter_if #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .ID_W(ID_W)) bus ();

    sat_add_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
`ifdef SAT_ARB_STATS_EN
        .sat_count (sat_count),
`endif
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[idx*IN_W +: IN_W] = a;
        bus.req_b[idx*IN_W +: IN_W] = b;
    endtask

    task automatic xfer(input int idx, input logic [7:0] a, input logic [7:0] b);
        set_ops(idx, a, b);
        bus.req_valid = NREQ'(1) << idx;
        tick();
        bus.req_valid = '0;
    endtask

    task automatic check_rsp(input string tag, input logic v, input int id,
                             input int sum, input logic sat);
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'(v));
        check({tag, "_id"},    32'(bus.rsp_id),    32'(id));
        check({tag, "_sum"},   32'(bus.rsp_sum),   32'(sum));
        check({tag, "_sat"},   32'(bus.rsp_sat),   32'(sat));
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_b = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;

        // Requests during reset must not be accepted.
        bus.req_valid = 4'hF;
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        tick();
        check_rsp("rst", 1'b0, 0, 0, 1'b0);
        bus.req_valid = '0;
        rst_b = 1'b1;
        tick();

        // Single requester 2: 3+4=7.
        set_ops(2, 8'd3, 8'd4);
        bus.req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        check_rsp("single", 1'b1, 2, 7, 1'b0);
        tick();
        check("drain_valid", 32'(bus.rsp_valid), 32'h0);

        // Saturation boundary on requester 0.
        xfer(0, 8'd7, 8'd8);
        check_rsp("lim15", 1'b1, 0, 15, 1'b0);
        xfer(0, 8'd8, 8'd8);
        check_rsp("over16", 1'b1, 0, 15, 1'b1);
        xfer(0, 8'd255, 8'd255);
        check_rsp("max510", 1'b1, 0, 15, 1'b1);

        // Backpressure: response held, no grants while stalled.
        for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i), 8'd1);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'hF;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_ready", 32'(bus.req_ready), 32'h0);
            tick();
            check_rsp("stall", 1'b1, 0, 15, 1'b1);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("resume_ready", 32'(bus.req_ready), 32'h2);
        tick();
        check_rsp("resume1", 1'b1, 1, 2, 1'b0);
        tick();
        check_rsp("resume2", 1'b1, 2, 3, 1'b0);
        bus.req_valid = '0;

        // Park a response in a stall, then reset asynchronously.
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        check_rsp("park", 1'b1, 3, 4, 1'b0);
        #3;
        rst_b = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.rsp_valid), 32'h0);
        check("async_rst_id", 32'(bus.rsp_id), 32'h0);
        tick();
        rst_b = 1'b1;
        bus.rsp_ready = 1'b1;

        // Fairness from reset: grants 0,1,2,3,0,1,2,3 one per cycle.
        bus.req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("rr_ready", 32'(bus.req_ready), 32'(1 << (c % NREQ)));
            tick();
            check_rsp("rr", 1'b1, c % NREQ, (c % NREQ) + 1, 1'b0);
        end
        bus.req_valid = '0;
        tick();
        check("rr_drain", 32'(bus.rsp_valid), 32'h0);

`ifdef SAT_ARB_STATS_EN
        check("stat_rst", 32'(sat_count), 32'h0);
        for (int c = 0; c < 8; c++) begin
            if (c < 5) xfer(0, 8'd9, 8'd9);
            else       xfer(0, 8'd1, 8'd1);
        end
        tick();
        check("stat_five", 32'(sat_count), 32'd5);
        force dut.r_sat_count = 16'hFFFF;
        #1;
        release dut.r_sat_count;
        xfer(0, 8'd200, 8'd100);
        tick();
        check("stat_hold", 32'(sat_count), 32'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
